// File: rtl/display_c2_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module : display_c2_mux_pkg
// Brief  : Glyph codes, active-high segment patterns and FSM encodings shared
//          by the signed multiplexed 7-segment driver.
// Rev    : 1.0
// ============================================================================
package display_c2_mux_pkg;

    // glyph codes 0..9 are the decimal numerals themselves
    localparam logic [3:0] c_gly_blank = 4'hA;
    localparam logic [3:0] c_gly_minus = 4'hB;

    // active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_seg_0     = 7'h3F;
    localparam logic [6:0] c_seg_1     = 7'h06;
    localparam logic [6:0] c_seg_2     = 7'h5B;
    localparam logic [6:0] c_seg_3     = 7'h4F;
    localparam logic [6:0] c_seg_4     = 7'h66;
    localparam logic [6:0] c_seg_5     = 7'h6D;
    localparam logic [6:0] c_seg_6     = 7'h7D;
    localparam logic [6:0] c_seg_7     = 7'h07;
    localparam logic [6:0] c_seg_8     = 7'h7F;
    localparam logic [6:0] c_seg_9     = 7'h6F;
    localparam logic [6:0] c_seg_blank = 7'h00;
    localparam logic [6:0] c_seg_minus = 7'h40;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_conv = 2'd1;
    localparam logic [1:0] c_st_upd  = 2'd2;

    // ceil(width*log10(2)) + 1 BCD nibbles, log10(2) approximated as 0.30103
    function automatic int nb_for(input int width);
        return (width * 30103 + 99999) / 100000 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_c2_mux_seg7_glyph.sv
`default_nettype none
// ============================================================================
// Module : seg7_glyph
// Brief  : Combinational glyph code to active-high 7-segment pattern.
// Rev    : 1.0
// ============================================================================
module seg7_glyph
    import display_c2_mux_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_seg_blank;
        case (i_code)
            4'd0:        o_seg = c_seg_0;
            4'd1:        o_seg = c_seg_1;
            4'd2:        o_seg = c_seg_2;
            4'd3:        o_seg = c_seg_3;
            4'd4:        o_seg = c_seg_4;
            4'd5:        o_seg = c_seg_5;
            4'd6:        o_seg = c_seg_6;
            4'd7:        o_seg = c_seg_7;
            4'd8:        o_seg = c_seg_8;
            4'd9:        o_seg = c_seg_9;
            c_gly_minus: o_seg = c_seg_minus;
            default:     o_seg = c_seg_blank;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/display_c2_mux.sv
`default_nettype none
// ============================================================================
// Module : display_c2_mux
// Brief  : Signed value capture, sequential double-dabble BCD conversion and
//          time-multiplexed 7-segment scan with sign and overflow glyphs.
// Rev    : 1.0
// ============================================================================
module display_c2_mux
    import display_c2_mux_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  valor,
    input  logic              load,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int NB = nb_for(WIDTH);
    localparam int XB = (NB > DIGITS) ? NB : DIGITS;
    localparam int CW = $clog2(WIDTH);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    localparam logic [CW-1:0]     c_last_bit     = CW'(WIDTH - 1);
    localparam logic [RW-1:0]     c_refresh_last = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]     c_idx_last     = IW'(DIGITS - 1);
    localparam logic              c_low          = (ACTIVE_LOW != 0);
    localparam logic [6:0]        c_seg_off      = c_low ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] c_an_off       = c_low ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [1:0]              r_state;
    logic [CW-1:0]           r_cnt;
    logic                    r_sign;
    logic [WIDTH-1:0]        r_mag;
    logic [4*NB-1:0]         r_bcd;
    logic [DIGITS-1:0][3:0]  r_glyph;
    logic                    r_overflow;
    logic [RW-1:0]           r_refresh;
    logic [IW-1:0]           r_idx;
    logic [6:0]              r_seg;
    logic [DIGITS-1:0]       r_an;

    logic [WIDTH-1:0]        w_abs;
    logic [4*NB-1:0]         w_adj;
    logic [4*XB-1:0]         w_bcdx;
    logic                    w_ovf;
    logic                    w_seen;
    logic [DIGITS-1:0][3:0]  w_glyph_nx;
    logic [DIGITS-1:0]       w_onehot;
    logic [3:0]              w_cur;
    logic [6:0]              w_seg_ah;

    // -2^(WIDTH-1) negates to itself, which read unsigned is the right magnitude
    assign w_abs = valor[WIDTH-1] ? (~valor + WIDTH'(1)) : valor;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NB; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_bcdx = '0;
        w_bcdx[4*NB-1:0] = r_bcd;
        w_ovf = 1'b0;
        for (int i = DIGITS - 1; i < XB; i++) begin
            if (w_bcdx[4*i +: 4] != 4'd0) w_ovf = 1'b1;
        end
        // scan from the most significant magnitude digit to blank leading zeros
        w_seen = 1'b0;
        w_glyph_nx = '0;
        for (int i = DIGITS - 2; i >= 0; i--) begin
            if ((w_bcdx[4*i +: 4] != 4'd0) || (i == 0)) w_seen = 1'b1;
            w_glyph_nx[i] = w_ovf ? c_gly_minus : (w_seen ? w_bcdx[4*i +: 4] : c_gly_blank);
        end
        w_glyph_nx[DIGITS-1] = (w_ovf || (r_sign && (r_bcd != '0))) ? c_gly_minus : c_gly_blank;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_mag      <= '0;
            r_bcd      <= '0;
            r_glyph    <= {DIGITS{c_gly_blank}};
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                c_st_conv: begin
                    r_bcd <= {w_adj[4*NB-2:0], r_mag[WIDTH-1]};
                    r_mag <= {r_mag[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last_bit) r_state <= c_st_upd;
                end
                c_st_idle, c_st_upd: begin
                    if (r_state == c_st_upd) begin
                        r_glyph    <= w_glyph_nx;
                        r_overflow <= w_ovf;
                    end
                    r_state <= c_st_idle;
                    if (load) begin
                        r_sign  <= valor[WIDTH-1];
                        r_mag   <= w_abs;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_st_conv;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign w_onehot = DIGITS'(1) << r_idx;
    assign w_cur    = r_glyph[r_idx];

    seg7_glyph u_glyph (
        .i_code (w_cur),
        .o_seg  (w_seg_ah)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_seg     <= c_seg_off;
            r_an      <= c_an_off;
        end else begin
            if (r_refresh == c_refresh_last) begin
                r_refresh <= '0;
                r_idx     <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
            // enable and pattern come from the same index so they switch together
            r_an  <= c_low ? ~w_onehot : w_onehot;
            r_seg <= c_low ? ~w_seg_ah : w_seg_ah;
        end
    end

    assign busy     = (r_state == c_st_conv);
    assign overflow = r_overflow;
    assign seg      = r_seg;
    assign an       = r_an;

endmodule
`default_nettype wire

// File: tb/tb_display_c2_mux.sv
`default_nettype none
// ============================================================================
// Module : tb_display_c2_mux
// Brief  : Directed vector bench for display_c2_mux (4-digit and 3-digit builds).
// Rev    : 1.0
// ============================================================================
module tb_display_c2_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] valor_a = '0, valor_b = '0;
    logic       load_a = 1'b0, load_b = 1'b0;
    logic       busy_a, busy_b, ovf_a, ovf_b;
    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a;
    logic [2:0] an_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    display_c2_mux #(.WIDTH(8), .DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst(rst), .valor(valor_a), .load(load_a),
        .busy(busy_a), .overflow(ovf_a), .seg(seg_a), .an(an_a)
    );

    display_c2_mux #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst(rst), .valor(valor_b), .load(load_b),
        .busy(busy_b), .overflow(ovf_b), .seg(seg_b), .an(an_b)
    );

    localparam logic [3:0] B = 4'hA;
    localparam logic [3:0] M = 4'hB;

    typedef struct {
        logic [7:0] v;
        logic [3:0] g3, g2, g1, g0;
        logic       ovf;
    } vec_t;

    // active-low pattern for each glyph code
    function automatic logic [6:0] glyph_seg(input logic [3:0] g);
        case (g)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  4'hB: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_digit(input bit sel, input int d, input logic [3:0] g, input string nm);
        logic [3:0] tgt;
        logic [3:0] cur;
        int w;
        tgt = 4'b1 << d;
        tgt = ~tgt;
        if (sel) tgt[3] = 1'b0;
        w = 0;
        cur = sel ? {1'b0, an_b} : an_a;
        while (cur !== tgt && w < 40) begin
            @(negedge clk);
            w++;
            cur = sel ? {1'b0, an_b} : an_a;
        end
        if (w >= 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: digit enable never seen, an=%0h wanted %0h", nm, cur, tgt);
        end else begin
            check(nm, sel ? seg_b : seg_a, glyph_seg(g));
        end
    endtask

    task automatic do_load(input bit sel, input logic [7:0] v, input string nm);
        int cnt;
        if (sel) begin valor_b = v; load_b = 1'b1; end
        else     begin valor_a = v; load_a = 1'b1; end
        @(negedge clk);
        load_a = 1'b0;
        load_b = 1'b0;
        cnt = 0;
        while ((sel ? busy_b : busy_a) && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check({nm, " busy cycles"}, cnt, 8);
        repeat (3) @(negedge clk);
    endtask

    vec_t vecs[7];

    initial begin
        logic [3:0] exp_an;
        int cnt;

        vecs[0] = '{8'd37,   B, B, 4'd3, 4'd7, 1'b0};
        vecs[1] = '{8'h80,   M, 4'd1, 4'd2, 4'd8, 1'b0};
        vecs[2] = '{8'd0,    B, B, B, 4'd0, 1'b0};
        vecs[3] = '{8'hFF,   M, B, B, 4'd1, 1'b0};
        vecs[4] = '{8'd100,  B, 4'd1, 4'd0, 4'd0, 1'b0};
        vecs[5] = '{8'hFB,   M, B, B, 4'd5, 1'b0};
        vecs[6] = '{8'd127,  B, 4'd1, 4'd2, 4'd7, 1'b0};

        // reset state
        repeat (2) @(negedge clk);
        check("reset an", an_a, 4'hF);
        check("reset seg", seg_a, 7'h7F);
        check("reset busy", busy_a, 0);
        check("reset overflow", ovf_a, 0);
        check("reset an_b", an_b, 3'h7);
        rst = 1'b0;

        // scan order and dwell after release
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_an = 4'b1 << (k / 4);
            exp_an = ~exp_an;
            check($sformatf("scan an step %0d", k), an_a, exp_an);
        end

        for (int i = 0; i < 7; i++) begin
            do_load(1'b0, vecs[i].v, $sformatf("vec%0d", i));
            check($sformatf("vec%0d overflow", i), ovf_a, vecs[i].ovf);
            check_digit(1'b0, 3, vecs[i].g3, $sformatf("vec%0d d3", i));
            check_digit(1'b0, 2, vecs[i].g2, $sformatf("vec%0d d2", i));
            check_digit(1'b0, 1, vecs[i].g1, $sformatf("vec%0d d1", i));
            check_digit(1'b0, 0, vecs[i].g0, $sformatf("vec%0d d0", i));
        end

        // 3-digit build: overflow then recovery
        do_load(1'b1, 8'd127, "b127");
        check("b127 overflow", ovf_b, 1);
        check_digit(1'b1, 2, M, "b127 d2");
        check_digit(1'b1, 1, M, "b127 d1");
        check_digit(1'b1, 0, M, "b127 d0");
        do_load(1'b1, 8'd5, "b5");
        check("b5 overflow", ovf_b, 0);
        check_digit(1'b1, 2, B, "b5 d2");
        check_digit(1'b1, 1, B, "b5 d1");
        check_digit(1'b1, 0, 4'd5, "b5 d0");

        // load while busy is ignored
        valor_a = 8'd12; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        repeat (2) @(negedge clk);
        valor_a = 8'd99; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        cnt = 0;
        while (busy_a && cnt < 50) begin cnt++; @(negedge clk); end
        check("busy load busy cycles left", cnt, 5);
        repeat (3) @(negedge clk);
        check_digit(1'b0, 3, B, "ignored d3");
        check_digit(1'b0, 2, B, "ignored d2");
        check_digit(1'b0, 1, 4'd1, "ignored d1");
        check_digit(1'b0, 0, 4'd2, "ignored d0");

        // reset mid-conversion aborts and blanks
        valor_a = 8'd55; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        check("abort busy before rst", busy_a, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", busy_a, 0);
        check("abort an", an_a, 4'hF);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort overflow", ovf_a, 0);
        check_digit(1'b0, 0, B, "abort d0");
        check_digit(1'b0, 1, B, "abort d1");
        check_digit(1'b0, 2, B, "abort d2");
        check_digit(1'b0, 3, B, "abort d3");
        check("abort still idle", busy_a, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
